// File: rtl/tick_generator.sv
// ---------------------------------------------------------------------------
// tick_generator
//   Multi-channel programmable tick / clock-enable generator. Every channel
//   owns a counter that wraps after `div` cycles, producing a one-cycle
//   registered strobe (tick) and a 50%-duty divided clock (clk_out) that
//   toggles on every tick. Divisors can be rewritten at runtime; a new value
//   is held as pending and only takes effect on the channel's wrap, so the
//   period changes without runt pulses.
//
//   Optional feature macro: TICKGEN_PAUSE_EN (adds the per-channel pause port).
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sync_clr     synchronous realign of all channels (cnt/clk_out/tick -> 0,
//                pending divisors applied at once)
//   div_wr_en    divisor write strobe
//   div_wr_ch    target channel; values >= NUM_CH are ignored
//   div_wr_data  new divisor (0 disables the channel)
//   pause        per-channel freeze (TICKGEN_PAUSE_EN only)
//   tick         1-cycle strobe at end of each channel period
//   clk_out      toggles on every tick
//   div_pending  a written divisor is waiting to be applied
// ---------------------------------------------------------------------------

// Per-channel counter, divisor register and pending-write slot.
module tick_channel #(
    parameter int              CNT_W   = 21,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             wr_en,
    input  logic [CNT_W-1:0] wr_data,
    input  logic             pause,
    output logic             tick,
    output logic             clk_out,
    output logic             div_pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pend;
    logic             wrap;
    logic             apply;

    always_comb begin
        wrap  = (div != '0) && (cnt == div - CNT_W'(1));
        // A pending divisor lands on sync_clr, on a wrap, or straight away
        // when the channel is disabled (no wrap would ever come). A paused
        // channel keeps the old divisor until it runs again.
        apply = div_pending && (sync_clr || (!pause && ((div == '0) || wrap)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div         <= DIV_RST;
            pend        <= '0;
            div_pending <= 1'b0;
            tick        <= 1'b0;
            clk_out     <= 1'b0;
        end else begin
            // A write in the same cycle as an apply refills the slot: the
            // apply uses the old pend (NBA read), the new value waits.
            if (wr_en) begin
                pend        <= wr_data;
                div_pending <= 1'b1;
            end else if (apply) begin
                div_pending <= 1'b0;
            end

            if (apply)
                div <= pend;

            if (sync_clr) begin
                cnt     <= '0;
                tick    <= 1'b0;
                clk_out <= 1'b0;
            end else if (pause) begin
                tick <= 1'b0;
            end else if (div == '0) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_out <= ~clk_out;
            end else begin
                cnt  <= cnt + CNT_W'(1);
                tick <= 1'b0;
            end
        end
    end

endmodule

module tick_generator #(
    parameter int                      NUM_CH   = 2,
    parameter int                      CNT_W    = 21,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {21'd833333, 21'd2},
    localparam int                     CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic              div_wr_en,
    input  logic [CH_W-1:0]   div_wr_ch,
    input  logic [CNT_W-1:0]  div_wr_data,
`ifdef TICKGEN_PAUSE_EN
    input  logic [NUM_CH-1:0] pause,
`endif
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] div_pending
);

    // NUM_CH always fits in CH_W+1 bits, so the range check is exact even
    // when NUM_CH is not a power of two.
    localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

    logic              wr_ok;
    logic [NUM_CH-1:0] pause_int;

    assign wr_ok = div_wr_en && ({1'b0, div_wr_ch} < NUM_CH_V);

`ifdef TICKGEN_PAUSE_EN
    assign pause_int = pause;
`else
    assign pause_int = '0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tick_channel #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .sync_clr    (sync_clr),
            .wr_en       (wr_ok && (div_wr_ch == CH_W'(i))),
            .wr_data     (div_wr_data),
            .pause       (pause_int[i]),
            .tick        (tick[i]),
            .clk_out     (clk_out[i]),
            .div_pending (div_pending[i])
        );
    end

endmodule

// File: tb/tb_tick_generator.sv
// ---------------------------------------------------------------------------
// tb_tick_generator
//   Directed bench for tick_generator. Main instance: NUM_CH=2, CNT_W=8,
//   ch0 div=2, ch1 div=5. Step k counts posedges after the second reset
//   release; outputs are sampled 1 time unit after each posedge.
//   A second 3-channel instance (all channels disabled at reset) covers the
//   out-of-range channel select, which a 1-bit select cannot express, and
//   the div==1 case.
// ---------------------------------------------------------------------------
module tb_tick_generator;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, sync_clr, wr_en;
    logic [0:0] wr_ch;
    logic [7:0] wr_data;
    logic [1:0] pause, tick, clk_out, pend;

    logic       wr3_en;
    logic [1:0] wr3_ch;
    logic [7:0] wr3_data;
    logic [2:0] pause3, tick3, clk3, pend3;

    int n_tests = 0;
    int n_fail  = 0;

    tick_generator #(.NUM_CH(2), .CNT_W(8), .DIV_INIT({8'd5, 8'd2})) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .div_wr_en(wr_en), .div_wr_ch(wr_ch), .div_wr_data(wr_data),
`ifdef TICKGEN_PAUSE_EN
        .pause(pause),
`endif
        .tick(tick), .clk_out(clk_out), .div_pending(pend)
    );

    tick_generator #(.NUM_CH(3), .CNT_W(8), .DIV_INIT(24'h0)) dut3 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .div_wr_en(wr3_en), .div_wr_ch(wr3_ch), .div_wr_data(wr3_data),
`ifdef TICKGEN_PAUSE_EN
        .pause(pause3),
`endif
        .tick(tick3), .clk_out(clk3), .div_pending(pend3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] sb(input string s, input int j);
        return (s[j] == "1") ? 8'd1 : 8'd0;
    endfunction

    string t0, t1, c0, c1, s;
    int    k;
    int    exp5[7];

    initial begin
        rst_n = 1'b0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = 1'b0; wr_data = 8'd0;
        pause = 2'b00; wr3_en = 1'b0; wr3_ch = 2'd0; wr3_data = 8'd0; pause3 = 3'b000;

        // ---- reset state ----
        step(); step();
        chk("rst tick",    8'(tick),    8'h0);
        chk("rst clk_out", 8'(clk_out), 8'h0);
        chk("rst pend",    8'(pend),    8'h0);

        // ---- run a little, leave a pending write, then reset mid-count ----
        rst_n = 1'b1;
        step();
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'd9;
        step();
        wr_en = 1'b0;
        chk("pend before rst", 8'(pend), 8'h2);
        step();
        chk("clk_out mid-count", 8'(clk_out), 8'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst tick",    8'(tick),    8'h0);
        chk("async rst clk_out", 8'(clk_out), 8'h0);
        chk("async rst pend",    8'(pend),    8'h0);
        step();
        rst_n = 1'b1;

        // ---- free run k=1..20: ch0 div 2, ch1 div 5 (pending 9 was lost) ----
        t0 = "01010101010101010101";
        t1 = "00001000010000100001";
        c0 = "01100110011001100110";
        c1 = "00001111100000111110";
        for (int j = 0; j < 20; j++) begin
            step();
            chk($sformatf("run tick0 k=%0d", j + 1),    8'(tick[0]),    sb(t0, j));
            chk($sformatf("run tick1 k=%0d", j + 1),    8'(tick[1]),    sb(t1, j));
            chk($sformatf("run clk_out0 k=%0d", j + 1), 8'(clk_out[0]), sb(c0, j));
            chk($sformatf("run clk_out1 k=%0d", j + 1), 8'(clk_out[1]), sb(c1, j));
        end

        // ---- speed-up: ch1 <= 3 written at k=22 (cnt 2), applied at k=25 wrap ----
        step(); // k21
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'd3;
        step(); // k22
        wr_en = 1'b0;
        chk("speedup pend k22", 8'(pend[1]), 8'h1);
        step(); chk("speedup pend k23", 8'(pend[1]), 8'h1);
        step(); chk("speedup pend k24", 8'(pend[1]), 8'h1);
        chk("speedup no tick k24", 8'(tick[1]), 8'h0);
        step(); // k25
        chk("speedup tick k25", 8'(tick[1]), 8'h1);
        chk("speedup pend clr k25", 8'(pend[1]), 8'h0);
        t1 = "001001"; c1 = "110001";
        for (int j = 0; j < 6; j++) begin
            step(); // k26..31
            chk($sformatf("div3 tick1 k=%0d", 26 + j),    8'(tick[1]),    sb(t1, j));
            chk($sformatf("div3 clk_out1 k=%0d", 26 + j), 8'(clk_out[1]), sb(c1, j));
        end

        // ---- write 0: ch1 stops after next tick, clk_out frozen high ----
        step(); step(); step(); // k32..34
        chk("div3 tick1 k34", 8'(tick[1]), 8'h1);
        chk("div3 clk1 k34",  8'(clk_out[1]), 8'h0);
        wr_en = 1'b1; wr_data = 8'd0;
        step(); // k35
        wr_en = 1'b0;
        chk("div0 pend k35", 8'(pend[1]), 8'h1);
        step(); step(); // k37
        chk("div0 last tick k37", 8'(tick[1]),    8'h1);
        chk("div0 clk1 k37",      8'(clk_out[1]), 8'h1);
        chk("div0 pend clr k37",  8'(pend[1]),    8'h0);
        for (int j = 0; j < 5; j++) begin
            step(); // k38..42
            chk($sformatf("stopped tick1 k=%0d", 38 + j), 8'(tick[1]),    8'h0);
            chk($sformatf("stopped clk1 k=%0d", 38 + j),  8'(clk_out[1]), 8'h1);
        end

        // ---- write 4 while disabled: applied next cycle, tick 4 later ----
        wr_en = 1'b1; wr_data = 8'd4;
        step(); // k43
        wr_en = 1'b0;
        chk("div4 pend k43", 8'(pend[1]), 8'h1);
        t1 = "00001";
        for (int j = 0; j < 5; j++) begin
            step(); // k44..48
            chk($sformatf("div4 tick1 k=%0d", 44 + j), 8'(tick[1]), sb(t1, j));
            if (j == 0) chk("div4 pend applied k44", 8'(pend[1]), 8'h0);
        end
        chk("div4 clk1 k48", 8'(clk_out[1]), 8'h0);

        // ---- write 7 in the wrap cycle (k52): period 4 kept once more ----
        step(); step(); step(); // k49..51
        wr_en = 1'b1; wr_data = 8'd7;
        step(); // k52
        wr_en = 1'b0;
        chk("wrapwr tick k52", 8'(tick[1]), 8'h1);
        chk("wrapwr pend k52", 8'(pend[1]), 8'h1);
        t1 = "0001";
        for (int j = 0; j < 4; j++) begin
            step(); // k53..56
            chk($sformatf("wrapwr tick1 k=%0d", 53 + j), 8'(tick[1]), sb(t1, j));
            if (j == 2) chk("wrapwr pend k55", 8'(pend[1]), 8'h1);
        end
        chk("wrapwr pend clr k56", 8'(pend[1]), 8'h0);
        t1 = "0000001";
        for (int j = 0; j < 7; j++) begin
            step(); // k57..63
            chk($sformatf("div7 tick1 k=%0d", 57 + j), 8'(tick[1]), sb(t1, j));
        end

        // ---- sync_clr with ch0=4 pending ----
        step(); // k64
        wr_en = 1'b1; wr_ch = 1'b0; wr_data = 8'd4;
        step(); // k65
        wr_en = 1'b0;
        chk("sync pend k65",    8'(pend),       8'h1);
        chk("sync clk1 pre k65", 8'(clk_out[1]), 8'h1);
        sync_clr = 1'b1;
        step(); // k66
        sync_clr = 1'b0;
        chk("sync clk_out k66", 8'(clk_out), 8'h0);
        chk("sync tick k66",    8'(tick),    8'h0);
        chk("sync pend k66",    8'(pend),    8'h0);
        exp5 = '{0, 0, 0, 1, 0, 0, 2};
        for (int j = 0; j < 7; j++) begin
            step(); // k67..73
            chk($sformatf("post-sync tick k=%0d", 67 + j), 8'(tick), 8'(exp5[j]));
        end
        chk("post-sync clk_out k73", 8'(clk_out), 8'h3);
        k = 73;

`ifdef TICKGEN_PAUSE_EN
        // ---- pause ch1 for 7 cycles at cnt 2: tick moves from k80 to k87 ----
        step(); step(); // k74, k75
        pause = 2'b10;
        for (int j = 0; j < 7; j++) begin
            step(); // k76..82
            chk($sformatf("paused tick1 k=%0d", 76 + j), 8'(tick[1]),    8'h0);
            chk($sformatf("paused clk1 k=%0d", 76 + j),  8'(clk_out[1]), 8'h1);
            chk($sformatf("unpaused tick0 k=%0d", 76 + j), 8'(tick[0]),
                (j == 2 || j == 6) ? 8'h1 : 8'h0);
        end
        pause = 2'b00;
        t1 = "00001";
        for (int j = 0; j < 5; j++) begin
            step(); // k83..87
            chk($sformatf("resume tick1 k=%0d", 83 + j), 8'(tick[1]), sb(t1, j));
        end
        k = 87;
`endif

        // ---- 3-channel instance: out-of-range select, then div 1 ----
        wr3_en = 1'b1; wr3_ch = 2'd3; wr3_data = 8'd1;
        step();
        wr3_en = 1'b0;
        chk("ch3 ignored pend", 8'(pend3), 8'h0);
        step();
        chk("ch3 ignored tick", 8'(tick3), 8'h0);
        chk("ch3 ignored pend2", 8'(pend3), 8'h0);
        wr3_en = 1'b1; wr3_ch = 2'd2; wr3_data = 8'd1;
        step();
        wr3_en = 1'b0;
        chk("ch2 pend", 8'(pend3), 8'h4);
        step();
        chk("ch2 applied pend", 8'(pend3), 8'h0);
        chk("ch2 applied tick", 8'(tick3), 8'h0);
        s = "111";
        for (int j = 0; j < 3; j++) begin
            step();
            chk($sformatf("div1 tick %0d", j),  8'(tick3), 8'h4);
            chk($sformatf("div1 clk %0d", j),   8'(clk3),  (s[j] == "1" && (j % 2 == 0)) ? 8'h4 : 8'h0);
        end
        k = k + 7;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
